// File: rtl/usb_pkg.sv
// Shared definitions for the USB device core endpoint blocks: endpoint FSM
// state encoding, packet-length width and the endpoint numbers assigned to
// the OUT-side command receiver and the IN-side telemetry transmitter.
package usb_pkg;

    // Endpoint transmitter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ep_tx_state_t;

    // Width of the packet byte-count field presented to the core
    localparam int USB_LEN_W = 12;

    // Endpoint numbers used by this device
    localparam logic [3:0] CMD_RX_EP = 4'd1;
    localparam logic [3:0] IN_TX_EP  = 4'd2;

    // Width of a byte-count that can describe 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Single-clock show-ahead byte FIFO with an explicit level counter, full flag
// and a sticky overflow flag. The head byte is visible on rd_data_o whenever
// the FIFO is non-empty; a pop retires it and the next byte appears on the
// following cycle. A write into a full FIFO is still accepted when a pop
// frees a slot in the same cycle.
module sync_fifo_sa #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    input  logic                     ovf_clr_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               rd_data_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Depth must be a power of two so the pointers wrap on their own
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("sync_fifo_sa: DEPTH must be a power of two and at least 2");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic empty;
    logic rd_fire;
    logic wr_accept;
    logic wr_drop;

    assign empty     = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    // A pop of an empty FIFO is meaningless, so it is masked here as well
    assign rd_fire   = pop_i && !empty;
    assign wr_accept = wr_en_i && (!full_o || rd_fire);
    assign wr_drop   = wr_en_i && full_o && !rd_fire;

    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign rd_data_o  = empty ? 8'h00 : mem[rd_ptr_q];

    // Next-state for pointers, level and overflow flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire)   rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_accept, rd_fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A fresh drop outranks a clear arriving in the same cycle
        if (wr_drop)        ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= wr_data_i;
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/usb_in_ep_tx.sv
// IN-endpoint transmitter. Fabric logic streams status bytes into a FIFO;
// when the host polls this endpoint the block snapshots up to MAX_PKT of the
// buffered bytes as one packet and hands them to the core one txpop at a
// time. Only popped bytes leave the FIFO; there is no retransmit copy.
module usb_in_ep_tx
    import usb_pkg::*;
#(
    parameter int         DEPTH   = 64,
    parameter logic [3:0] EP_NUM  = IN_TX_EP,
    parameter int         MAX_PKT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    input  logic [3:0]               endpt,
    input  logic                     txact,
    input  logic                     txpop,
    output logic                     txval,
    output logic                     txcork,
    output logic [7:0]               txdat,
    output logic [USB_LEN_W-1:0]     txdat_len
);

    localparam int            LW        = level_width(DEPTH);
    localparam logic [LW-1:0] MAX_PKT_L = LW'(MAX_PKT);

    // A packet can never be longer than the FIFO can hold
    if ((MAX_PKT < 1) || (MAX_PKT > DEPTH)) begin : g_bad_max_pkt
        $error("usb_in_ep_tx: MAX_PKT must be in 1..DEPTH");
    end
    if (LW > USB_LEN_W) begin : g_bad_len_w
        $error("usb_in_ep_tx: DEPTH too large for the packet length field");
    end

    ep_tx_state_t   state_q, state_d;
    logic           txact_q;
    logic [LW-1:0]  remaining_q, remaining_d;
    logic [USB_LEN_W-1:0] len_q, len_d;

    logic          act_rise;
    logic          ep_hit;
    logic          pop_now;
    logic [LW-1:0] snap_len;

    assign act_rise = txact && !txact_q;
    assign ep_hit   = (endpt == EP_NUM);
    // Pops count only inside the snapshot window and only while data exists
    assign pop_now  = txpop && (state_q == SEND) && (remaining_q != '0) && (level != '0);
    assign snap_len = (level > MAX_PKT_L) ? MAX_PKT_L : level;

    sync_fifo_sa #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .pop_i      (pop_now),
        .ovf_clr_i  (ovf_clr),
        .full_o     (full),
        .level_o    (level),
        .rd_data_o  (txdat),
        .overflow_o (overflow)
    );

    // Endpoint FSM next-state: snapshot on poll, count pops, wait for txact low
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        case (state_q)
            IDLE: begin
                if (act_rise && ep_hit) begin
                    len_d       = USB_LEN_W'(snap_len);
                    remaining_d = snap_len;
                    state_d     = (snap_len != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (pop_now) remaining_d = remaining_q - LW'(1);
                // The host may end the transaction early; unpopped bytes stay queued
                if ((pop_now && (remaining_q == LW'(1))) || !txact) state_d = DONE;
            end
            DONE: begin
                if (!txact) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        txval  = 1'b0;
        txcork = 1'b1;
        case (state_q)
            IDLE:    txcork = (level == '0);
            SEND: begin
                txval  = 1'b1;
                txcork = 1'b0;
            end
            default: begin
                txval  = 1'b0;
                txcork = 1'b1;
            end
        endcase
    end

    assign txdat_len = len_q;

    // FSM and edge-detect registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            txact_q     <= 1'b0;
            remaining_q <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            txact_q     <= txact;
            remaining_q <= remaining_d;
            len_q       <= len_d;
        end
    end

endmodule
